// File: rtl/pixel_packer_pkg.sv
// Shared types and constants for the pixel packer: pixel type, AXI-Stream FIFO entry, packing phase.
package pixel_packer_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int PIX_W       = 24;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        logic                   tuser;
        logic                   tlast;
        logic [AXIS_DATA_W-1:0] data;
    } axis_word_t;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_e;

    function automatic axis_word_t mk_word(input logic tuser, input logic tlast,
                                           input logic [AXIS_DATA_W-1:0] data);
        axis_word_t w;
        w.tuser = tuser;
        w.tlast = tlast;
        w.data  = data;
        return w;
    endfunction

endpackage

// File: rtl/pixel_packer_if.sv
// AXI4-Stream video output bundle driven by the pixel packer towards the VDMA.
interface pixel_packer_if;
    import pixel_packer_pkg::*;

    logic [AXIS_DATA_W-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tuser;
    logic                   tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/word_fifo_2w1r.sv
// Word FIFO taking 0..2 entries per cycle and delivering one; a write batch that does not fit is dropped whole.
module word_fifo_2w1r
    import pixel_packer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               wr_cnt,
    input  axis_word_t               wr_data0,
    input  axis_word_t               wr_data1,
    input  logic                     rd_en,
    output axis_word_t               rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    axis_word_t    mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [AW:0]   count_s;
    logic [AW:0]   free_s;
    logic [AW:0]   wr_n_s;
    logic [AW-1:0] wr_idx1_s;
    logic          rd_s;
    logic          wr_ok_s;

    // Occupancy bookkeeping; a same-cycle read frees a slot for this cycle's writes.
    always_comb begin
        empty     = (wr_ptr_r == rd_ptr_r);
        rd_s      = rd_en && !empty;
        count_s   = wr_ptr_r - rd_ptr_r;
        free_s    = DEPTH_W - count_s + {{AW{1'b0}}, rd_s};
        wr_ok_s   = (free_s >= {{(AW-1){1'b0}}, wr_cnt});
        dropped   = (wr_cnt != 2'd0) && !wr_ok_s;
        wr_n_s    = wr_ok_s ? {{(AW-1){1'b0}}, wr_cnt} : {(AW+1){1'b0}};
        occupancy = count_s - {{AW{1'b0}}, rd_s} + wr_n_s;
        wr_idx1_s = wr_ptr_r[AW-1:0] + {{(AW-1){1'b0}}, 1'b1};
        rd_data   = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Pointer update with wrap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + wr_n_s;
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, rd_s};
        end
    end

    // Storage array; contents are only observed once the pointers mark them valid.
    always_ff @(posedge clk) begin
        if (wr_ok_s && (wr_cnt != 2'd0)) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data0;
        end
        if (wr_ok_s && (wr_cnt == 2'd2)) begin
            mem_r[wr_idx1_s] <= wr_data1;
        end
    end

endmodule

// File: rtl/pixel_packer.sv
// Packs the 24-bit RGB shade stream into 32-bit AXI4-Stream words (4 pixels per 3 words)
// behind a word FIFO that absorbs VDMA backpressure.
module pixel_packer
    import pixel_packer_pkg::*;
#(
    parameter int COLOR_WIDTH = 24,
    parameter int FIFO_DEPTH  = 16,
    parameter int AF_MARGIN   = 4
) (
    input  logic                   clk,
    input  logic                   rst_gen,
    input  logic [COLOR_WIDTH-1:0] shade_in,
    input  logic                   valid_in,
    input  logic                   sof_in,
    input  logic                   eol_in,
    pixel_packer_if.master         m_axis,
    output logic                   almost_full,
    output logic                   overflow,
    output logic                   misalign
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] MARGIN_W = (AW+1)'(AF_MARGIN);

    pixel_t     in_pix_r;
    logic       in_vld_r, in_sof_r, in_eol_r;
    phase_e     phase_r, nxt_phase_s, eff_phase_s;
    pixel_t     res_r, nxt_res_s;
    logic       sof_pend_r, tuser_s;
    logic [1:0] wr_cnt_r, cnt_s;
    axis_word_t wr0_r, wr1_r, head_s;
    logic [31:0] w0_s, w1_s;
    logic       misalign_r, overflow_r, almost_full_r;
    logic       empty_s, drop_s;
    logic [AW:0] occ_s;

    // Packing decode: a sof pixel always restarts from phase 0, dropping any residue.
    always_comb begin
        eff_phase_s = in_sof_r ? PH0 : phase_r;
        tuser_s     = sof_pend_r | in_sof_r;
        w0_s        = 32'h0000_0000;
        w1_s        = 32'h0000_0000;
        cnt_s       = 2'd0;
        nxt_res_s   = res_r;
        nxt_phase_s = phase_r;
        if (in_vld_r) begin
            case (eff_phase_s)
                PH0: begin
                    if (in_eol_r) begin
                        w0_s        = {8'h00, in_pix_r};
                        cnt_s       = 2'd1;
                        nxt_phase_s = PH0;
                    end else begin
                        nxt_res_s   = in_pix_r;
                        nxt_phase_s = PH1;
                    end
                end
                PH1: begin
                    w0_s = {in_pix_r[7:0], res_r};
                    if (in_eol_r) begin
                        w1_s        = {16'h0000, in_pix_r[23:8]};
                        cnt_s       = 2'd2;
                        nxt_phase_s = PH0;
                    end else begin
                        cnt_s       = 2'd1;
                        nxt_res_s   = {8'h00, in_pix_r[23:8]};
                        nxt_phase_s = PH2;
                    end
                end
                PH2: begin
                    w0_s = {in_pix_r[15:0], res_r[15:0]};
                    if (in_eol_r) begin
                        w1_s        = {24'h00_0000, in_pix_r[23:16]};
                        cnt_s       = 2'd2;
                        nxt_phase_s = PH0;
                    end else begin
                        cnt_s       = 2'd1;
                        nxt_res_s   = {16'h0000, in_pix_r[23:16]};
                        nxt_phase_s = PH3;
                    end
                end
                PH3: begin
                    w0_s        = {in_pix_r, res_r[7:0]};
                    cnt_s       = 2'd1;
                    nxt_phase_s = PH0;
                end
                default: begin
                    cnt_s       = 2'd0;
                    nxt_phase_s = PH0;
                end
            endcase
        end else begin
            cnt_s = 2'd0;
        end
    end

    // Input capture, packing state, emit registers and sticky status flags.
    always_ff @(posedge clk or negedge rst_gen) begin
        if (!rst_gen) begin
            in_pix_r      <= '0;
            in_vld_r      <= 1'b0;
            in_sof_r      <= 1'b0;
            in_eol_r      <= 1'b0;
            phase_r       <= PH0;
            res_r         <= '0;
            sof_pend_r    <= 1'b0;
            wr_cnt_r      <= 2'd0;
            wr0_r         <= '0;
            wr1_r         <= '0;
            misalign_r    <= 1'b0;
            overflow_r    <= 1'b0;
            almost_full_r <= 1'b0;
        end else begin
            in_pix_r <= pixel_t'(shade_in);
            in_vld_r <= valid_in;
            in_sof_r <= sof_in;
            in_eol_r <= eol_in;
            phase_r  <= nxt_phase_s;
            res_r    <= nxt_res_s;
            if (in_vld_r && in_sof_r && (phase_r != PH0)) begin
                misalign_r <= 1'b1;
            end
            // The pending tuser is consumed by the first word emitted, even if that word is dropped.
            if (in_vld_r) begin
                sof_pend_r <= (cnt_s == 2'd0) ? tuser_s : 1'b0;
            end
            wr_cnt_r      <= cnt_s;
            wr0_r         <= mk_word(tuser_s, in_eol_r && (cnt_s == 2'd1), w0_s);
            wr1_r         <= mk_word(1'b0, 1'b1, w1_s);
            overflow_r    <= overflow_r | drop_s;
            almost_full_r <= ((DEPTH_W - occ_s) <= MARGIN_W);
        end
    end

    word_fifo_2w1r #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_gen),
        .wr_cnt    (wr_cnt_r),
        .wr_data0  (wr0_r),
        .wr_data1  (wr1_r),
        .rd_en     (m_axis.tready),
        .rd_data   (head_s),
        .empty     (empty_s),
        .occupancy (occ_s),
        .dropped   (drop_s)
    );

    assign m_axis.tvalid = !empty_s;
    assign m_axis.tdata  = empty_s ? 32'h0000_0000 : head_s.data;
    assign m_axis.tuser  = empty_s ? 1'b0 : head_s.tuser;
    assign m_axis.tlast  = empty_s ? 1'b0 : head_s.tlast;
    assign almost_full   = almost_full_r;
    assign overflow      = overflow_r;
    assign misalign      = misalign_r;

endmodule

// File: tb/tb_pixel_packer.sv
// Scoreboard bench for pixel_packer: a reference packing model queues expected words, a monitor pops and compares.
module tb_pixel_packer;
    import pixel_packer_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_gen;
    logic [23:0] shade_in;
    logic        valid_in, sof_in, eol_in;
    logic        almost_full, overflow, misalign;

    pixel_packer_if m_axis();

    pixel_packer #(
        .COLOR_WIDTH (24),
        .FIFO_DEPTH  (DEPTH),
        .AF_MARGIN   (4)
    ) dut (
        .clk         (clk),
        .rst_gen     (rst_gen),
        .shade_in    (shade_in),
        .valid_in    (valid_in),
        .sof_in      (sof_in),
        .eol_in      (eol_in),
        .m_axis      (m_axis),
        .almost_full (almost_full),
        .overflow    (overflow),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    logic [33:0] exp_q [$];
    int          m_phase;
    logic [23:0] m_res;
    logic        m_pend;
    logic        stall;
    logic        exp_ovf;
    logic        exp_mis;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_res   = 24'h0;
        m_pend  = 1'b0;
        exp_ovf = 1'b0;
        exp_mis = 1'b0;
        exp_q.delete();
    endtask

    // Reference packing, written directly from the word layouts of the format.
    task automatic model_pixel(input logic [23:0] pix, input logic sof, input logic eol);
        logic [31:0] w0, w1;
        int          n;
        logic        tu;
        w0 = 32'h0;
        w1 = 32'h0;
        n  = 0;
        if (sof) begin
            if (m_phase != 0) exp_mis = 1'b1;
            m_phase = 0;
            m_pend  = 1'b1;
        end
        tu = m_pend;
        case (m_phase)
            0: if (eol) begin w0 = {8'h00, pix}; n = 1; end else m_res = pix;
            1: begin
                w0 = {pix[7:0], m_res};
                if (eol) begin w1 = {16'h0, pix[23:8]}; n = 2; end
                else begin n = 1; m_res = {8'h0, pix[23:8]}; end
            end
            2: begin
                w0 = {pix[15:0], m_res[15:0]};
                if (eol) begin w1 = {24'h0, pix[23:16]}; n = 2; end
                else begin n = 1; m_res = {16'h0, pix[23:16]}; end
            end
            default: begin w0 = {pix, m_res[7:0]}; n = 1; end
        endcase
        m_phase = eol ? 0 : (m_phase + 1) % 4;
        if (n > 0) m_pend = 1'b0;
        if (n > 0 && stall && (exp_q.size() + n > DEPTH)) begin
            exp_ovf = 1'b1;
        end else if (n == 1) begin
            exp_q.push_back({tu, eol, w0});
        end else if (n == 2) begin
            exp_q.push_back({tu, 1'b0, w0});
            exp_q.push_back({1'b0, 1'b1, w1});
        end
    endtask

    task automatic send(input logic [23:0] pix, input logic sof, input logic eol);
        model_pixel(pix, sof, eol);
        shade_in = pix;
        sof_in   = sof;
        eol_in   = eol;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        eol_in   = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic monitor();
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rst_gen && m_axis.tvalid && m_axis.tready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {30'h0, m_axis.tuser, m_axis.tlast, m_axis.tdata}, {30'h0, e});
                end
            end
        end
    endtask

    initial begin
        logic [23:0] p;
        rst_gen       = 1'b0;
        shade_in      = 24'h0;
        valid_in      = 1'b0;
        sof_in        = 1'b0;
        eol_in        = 1'b0;
        m_axis.tready = 1'b1;
        stall         = 1'b0;
        model_reset();
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("rst_tuser", 64'(m_axis.tuser), 64'd0);
        check("rst_tlast", 64'(m_axis.tlast), 64'd0);
        check("rst_tdata", 64'(m_axis.tdata), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        check("rst_almost_full", 64'(almost_full), 64'd0);
        rst_gen = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic 4-pixel group, eol line close, restart, and single sof+eol pixel.
        send(24'h112233, 1'b1, 1'b0);
        send(24'h445566, 1'b0, 1'b0);
        send(24'h778899, 1'b0, 1'b0);
        send(24'hAABBCC, 1'b0, 1'b0);
        send(24'h112233, 1'b0, 1'b0);
        send(24'h445566, 1'b0, 1'b1);
        send(24'h778899, 1'b0, 1'b0);
        send(24'hAABBCC, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        send(24'h112233, 1'b1, 1'b1);
        send(24'h0000FF, 1'b0, 1'b0);
        send(24'h123456, 1'b0, 1'b0);
        send(24'hFEDCBA, 1'b0, 1'b1);
        wait_drain();

        // Backpressure: 40 continuous pixels with the sink stalled.
        m_axis.tready = 1'b0;
        stall         = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) check("af_low", 64'(almost_full), 64'd0);
            p = 24'h102030 + 24'(i * 65793);
            send(p, 1'b0, 1'b0);
        end
        repeat (6) @(posedge clk);
        #1;
        check("af_high", 64'(almost_full), 64'd1);
        check("overflow_set", 64'(overflow), 64'(exp_ovf));
        check("stall_depth", 64'(exp_q.size()), 64'(DEPTH));
        m_axis.tready = 1'b1;
        stall         = 1'b0;
        wait_drain();
        check("af_after_drain", 64'(almost_full), 64'd0);
        check("overflow_sticky", 64'(overflow), 64'(exp_ovf));

        // sof arriving at phase 2.
        send(24'h010203, 1'b0, 1'b0);
        send(24'h040506, 1'b0, 1'b0);
        send(24'h0A0B0C, 1'b1, 1'b0);
        send(24'h0D0E0F, 1'b0, 1'b0);
        send(24'h202122, 1'b0, 1'b1);
        wait_drain();
        check("misalign", 64'(misalign), 64'(exp_mis));

        // Asynchronous reset mid-line with words held in the FIFO.
        m_axis.tready = 1'b0;
        send(24'h313233, 1'b1, 1'b0);
        send(24'h343536, 1'b0, 1'b0);
        send(24'h373839, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_tvalid", 64'(m_axis.tvalid), 64'd1);
        #2;
        rst_gen = 1'b0;
        #1;
        check("async_rst_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("async_rst_tdata", 64'(m_axis.tdata), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_gen       = 1'b1;
        m_axis.tready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_overflow", 64'(overflow), 64'd0);
        check("post_rst_misalign", 64'(misalign), 64'd0);
        send(24'hC0C1C2, 1'b1, 1'b0);
        send(24'hC3C4C5, 1'b0, 1'b0);
        send(24'hC6C7C8, 1'b0, 1'b0);
        send(24'hC9CACB, 1'b0, 1'b0);
        wait_drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
